// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed 7-segment display (segment lines + digit enables) and
// rebuilds complete BCD frames, presenting them through a valid/ready handshake.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    input  logic                      frame_ready,
    output logic                      frame_valid,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     err_out,
    output logic                      overflow
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [7:0]            STABLE  = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Returns {err, bcd}; unknown patterns map to 0xF with err set.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    logic [7:0]              seg_q, prev_seg_q;
    logic [NUM_DIGITS-1:0]   dig_q, prev_dig_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
    logic [NUM_DIGITS-1:0]   work_dp_q, work_dp_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    ovf_q, ovf_d;

    logic       sample_ok, same, capture, complete, load;
    logic [4:0] dec;

    always_comb begin
        sample_ok = (dig_q != '0) && ((dig_q & (dig_q - DIG_ONE)) == '0);
        same      = ({seg_q, dig_q} == {prev_seg_q, prev_dig_q});
        dec       = decode(seg_q[6:0]);

        cnt_d = cnt_q;
        if (!sample_ok)
            cnt_d = 8'd0;
        else if (!same)
            cnt_d = 8'd1;
        else if (cnt_q != STABLE)
            cnt_d = cnt_q + 8'd1;

        // Only the edge on which the counter arrives at STABLE captures.
        capture  = (cnt_d == STABLE) && (cnt_q != STABLE);
        complete = &mask_q;

        work_bcd_d = work_bcd_q;
        work_dp_d  = work_dp_q;
        work_err_d = work_err_q;
        mask_d     = complete ? '0 : mask_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && dig_q[i]) begin
                work_bcd_d[4*i +: 4] = dec[3:0];
                work_dp_d[i]         = seg_q[7];
                work_err_d[i]        = dec[4];
                mask_d[i]            = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (complete) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (complete) begin
                    if (frame_ready) load  = 1'b1;
                    else             ovf_d = 1'b1;
                end else if (frame_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        bcd_d = load ? work_bcd_q : bcd_q;
        dp_d  = load ? work_dp_q  : dp_q;
        err_d = load ? work_err_q : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            dig_q      <= '0;
            prev_seg_q <= '0;
            prev_dig_q <= '0;
            cnt_q      <= '0;
            work_bcd_q <= '0;
            work_dp_q  <= '0;
            work_err_q <= '0;
            mask_q     <= '0;
            state_q    <= COLLECT;
            bcd_q      <= '0;
            dp_q       <= '0;
            err_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            seg_q      <= seg;
            dig_q      <= dig_en;
            prev_seg_q <= seg_q;
            prev_dig_q <= dig_q;
            cnt_q      <= cnt_d;
            work_bcd_q <= work_bcd_d;
            work_dp_q  <= work_dp_d;
            work_err_q <= work_err_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            dp_q       <= dp_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign frame_valid = (state_q == HOLD);
    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign err_out     = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random scanning, all checked
// against a run-length based frame model.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    seg;
    logic [ND-1:0] dig_en;
    logic          frame_ready;
    logic          frame_valid;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] dp_out, err_out;
    logic          overflow;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en),
        .frame_ready(frame_ready), .frame_valid(frame_valid),
        .bcd_out(bcd_out), .dp_out(dp_out), .err_out(err_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] legal [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Reference model state
    int          run;
    logic [11:0] prev_in;
    bit          cap_pend;
    logic [11:0] cap_val;
    logic [3:0]  m_mask;
    logic [15:0] w_bcd, m_bcd;
    logic [3:0]  w_dp, w_err, m_dp, m_err;
    logic        m_valid, m_ovf;

    // Frame observation helpers for directed checks
    int          pulses;
    logic        last_fv;
    logic [15:0] seen_bcd;
    logic [3:0]  seen_dp, seen_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; prev_in = '0; cap_pend = 0; cap_val = '0;
        m_mask = '0; w_bcd = '0; w_dp = '0; w_err = '0;
        m_bcd = '0; m_dp = '0; m_err = '0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic [7:0] s, input logic [3:0] d, input logic rdy);
        int idx;
        logic [3:0] val;
        logic bad;
        if (m_mask == 4'hF) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_bcd = w_bcd; m_dp = w_dp; m_err = w_err;
            end else begin
                m_ovf = 1;
            end
            m_mask = '0;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (cap_pend) begin
            idx = 0;
            for (int i = 0; i < ND; i++) if (cap_val[i]) idx = i;
            val = 4'hF; bad = 1;
            for (int k = 0; k < 10; k++)
                if (legal[k][6:0] == cap_val[10:4]) begin val = 4'(k); bad = 0; end
            w_bcd[4*idx +: 4] = val;
            w_dp[idx]  = cap_val[11];
            w_err[idx] = bad;
            m_mask[idx] = 1'b1;
        end
        if ($countones(d) != 1)      run = 0;
        else if ({s, d} == prev_in)  run++;
        else                         run = 1;
        cap_pend = ($countones(d) == 1) && (run == SC);
        cap_val  = {s, d};
        prev_in  = {s, d};
    endtask

    task automatic step(input logic [7:0] s, input logic [3:0] d, input logic rdy);
        seg = s; dig_en = d; frame_ready = rdy;
        @(posedge clk);
        model_edge(s, d, rdy);
        #1;
        check("cycle", {6'd0, frame_valid, overflow, err_out, dp_out, bcd_out},
              {6'd0, m_valid, m_ovf, m_err, m_dp, m_bcd});
        if (frame_valid && !last_fv) begin
            pulses++; seen_bcd = bcd_out; seen_dp = dp_out; seen_err = err_out;
        end
        last_fv = frame_valid;
    endtask

    task automatic dwell(input logic [7:0] s, input logic [3:0] d, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(s, d, rdy);
    endtask

    task automatic scan4(input logic [31:0] segs, input logic rdy);
        for (int i = 0; i < ND; i++) dwell(segs[8*i +: 8], 4'(1 << i), 8, rdy);
    endtask

    initial begin
        rst_n = 1; seg = '0; dig_en = '0; frame_ready = 0;
        last_fv = 0; pulses = 0; seen_bcd = '0; seen_dp = '0; seen_err = '0;
        model_reset();
        #2 rst_n = 0;
        #1;
        check("reset_outputs", {6'd0, frame_valid, overflow, err_out, dp_out, bcd_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Basic frame 4321 with ready held high
        pulses = 0;
        scan4({8'h66, 8'h4F, 8'h5B, 8'h06}, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("basic_pulses", pulses, 1);
        check("basic_bcd", seen_bcd, 16'h4321);
        check("basic_err_dp", {seen_err, seen_dp}, 8'h00);

        // Short dwell on digit 2 must not capture it
        pulses = 0;
        dwell(8'h06, 4'h1, 8, 1'b1);
        dwell(8'h5B, 4'h2, 8, 1'b1);
        dwell(8'h4F, 4'h4, 3, 1'b1);
        dwell(8'h66, 4'h8, 8, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("short_no_frame", pulses, 0);
        dwell(8'h4F, 4'h4, 4, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("short_later_frame", pulses, 1);
        check("short_bcd", seen_bcd, 16'h4321);

        // Illegal pattern and decimal point
        pulses = 0;
        scan4({8'h66, 8'h4F, 8'h86, 8'h49}, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("illegal_bcd", seen_bcd, 16'h431F);
        check("illegal_err", seen_err, 4'b0001);
        check("dp_capture", seen_dp, 4'b0010);

        // Backpressure: two frames, second dropped
        pulses = 0;
        scan4({8'h66, 8'h4F, 8'h5B, 8'h06}, 1'b0);
        scan4({8'h7F, 8'h07, 8'h7D, 8'h6D}, 1'b0);
        dwell(8'h00, 4'h0, 3, 1'b0);
        check("bp_first_frame", seen_bcd, 16'h4321);
        check("bp_held_bcd", bcd_out, 16'h4321);
        check("bp_overflow", overflow, 1'b1);
        check("bp_valid_held", frame_valid, 1'b1);
        step(8'h00, 4'h0, 1'b1);
        check("bp_release", frame_valid, 1'b0);
        dwell(8'h00, 4'h0, 3, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Multi-hot digit enable never captures
        pulses = 0;
        dwell(8'h06, 4'h3, 10, 1'b1);
        dwell(8'h00, 4'h0, 2, 1'b1);
        check("multihot_no_frame", pulses, 0);

        // Reset in the middle of a frame
        dwell(8'h6F, 4'h1, 8, 1'b1);
        dwell(8'h3F, 4'h2, 8, 1'b1);
        #2 rst_n = 0;
        #1;
        check("midreset_outputs", {6'd0, frame_valid, overflow, err_out, dp_out, bcd_out}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        pulses = 0;
        dwell(8'h7D, 4'h4, 8, 1'b1);
        dwell(8'h07, 4'h8, 8, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("midreset_no_frame", pulses, 0);
        scan4({8'h07, 8'h7D, 8'h3F, 8'h6F}, 1'b1);
        dwell(8'h00, 4'h0, 4, 1'b1);
        check("midreset_new_frame", pulses, 1);
        check("midreset_bcd", seen_bcd, 16'h7609);

        // Random scanning against the model
        for (int n = 0; n < 150; n++) begin
            logic [3:0] d;
            logic [7:0] s;
            int len;
            if ($urandom_range(0, 9) < 8) d = 4'(1 << $urandom_range(0, 3));
            else                          d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) != 0)
                s = {1'($urandom_range(0, 1)), legal[$urandom_range(0, 9)][6:0]};
            else
                s = 8'($urandom);
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++)
                step(s, d, 1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions observed.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (legal range 2-255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seg  input  8  segment lines, active-high; bit0=a … bit6=g, bit7=dp.
REQ-006 dig_en  input  NUM_DIGITS  digit select, active-high, one-hot when valid; bit0 = rightmost digit.
REQ-007 frame_ready  input  1  consumer accepts the presented frame.
REQ-008 frame_valid  output  1  a complete decoded frame is presented.
REQ-009 bcd_out  output  4*NUM_DIGITS  decoded BCD; nibble i belongs to dig_en[i].
REQ-010 dp_out  output  NUM_DIGITS  captured dp bit per digit.
REQ-011 err_out  output  NUM_DIGITS  per digit, 1 = captured pattern is not a legal digit.
REQ-012 overflow  output  1  sticky; a completed frame was dropped.

Function
REQ-013 Inputs seg and dig_en SHALL be registered once (sample stage) before any comparison.
REQ-014 Stability counter: increments, saturating at STABLE_CYCLES, while the sampled {seg,dig_en} equals the previous sample; reloads to 1 on any change.
REQ-015 A sample with dig_en zero or with more than one bit set SHALL hold the counter at 0 and never capture.
REQ-016 Capture occurs exactly once per stable period, on the edge where the counter reaches STABLE_CYCLES; no re-capture until the sample changes.
REQ-017 Decode table (seg[6:0] -> BCD): 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
REQ-018 Any other seg[6:0] pattern captures BCD 0xF with the digit's err bit set; dp is captured regardless.
REQ-019 Capture writes the working nibble, dp and err for the selected digit and sets its bit in a captured mask; re-capture of a digit already in the mask overwrites it.
REQ-020 FSM states: COLLECT (no frame presented) and HOLD (frame_valid=1).
REQ-021 Frame completion = captured mask all ones; on the following edge the working registers transfer to the outputs and the mask clears.
REQ-022 COLLECT -> HOLD on frame completion; frame_valid asserts on that same transfer edge.
REQ-023 HOLD -> COLLECT when frame_ready=1 and no completion pending; frame_valid deasserts on that edge.
REQ-024 In HOLD, collection continues; outputs SHALL remain stable until frame_ready=1.
REQ-025 Completion in HOLD with frame_ready=1 on the same edge: new frame loads, frame_valid stays 1, no overflow.
REQ-026 Completion in HOLD with frame_ready=0: the new frame is discarded, mask clears, overflow sets and holds until reset.
REQ-027 Latency: last digit stable STABLE_CYCLES sampled edges after its input change -> frame_valid high one edge after its capture.

Reset
REQ-028 On rst_n=0, asynchronously: frame_valid=0, bcd_out=0, dp_out=0, err_out=0, overflow=0, mask=0, counter=0, sample registers=0, state=COLLECT.
REQ-029 Reset asserted mid-frame SHALL discard partial captures; after release a full frame must be collected anew.

Verification
REQ-030 NUM_DIGITS=4, STABLE_CYCLES=4; scan dig_en 0001,0010,0100,1000 with seg 0x06,0x5B,0x4F,0x66, 8 cycles each, frame_ready=1 -> one frame_valid pulse with bcd_out=0x4321, err_out=0, dp_out=0.
REQ-031 Same scan with digit 2 held only 3 cycles -> no capture of digit 2 and no frame_valid until a later 4-cycle dwell on dig_en=0100.
REQ-032 seg=0x49 on dig_en=0001, others legal -> bcd_out[3:0]=0xF, err_out=0001; seg=0x86 on digit 1 -> nibble 1, dp_out[1]=1.
REQ-033 frame_ready=0, two complete frames scanned -> first frame held unchanged, overflow=1; then frame_ready=1 for one cycle -> frame_valid=0 next edge.
REQ-034 dig_en=0011 for 10 cycles -> no capture, mask unchanged; rst_n pulsed low after 2 of 4 digits captured -> all outputs 0 immediately; full new scan required for frame_valid.
